// File: rtl/axi_rd_rr_arb_pkg.sv
// Shared definitions for the AXI read round-robin arbiter.
// Holds default widths, the port-tag width and the AR FSM state enum.
package axi_rd_rr_arb_pkg;

    localparam int DEF_TAG_BITS   = 2;
    localparam int DEF_ID_WIDTH   = 16;
    localparam int ADDR_WIDTH     = 64;
    localparam int DATA_WIDTH     = 512;
    localparam int LEN_WIDTH      = 8;
    localparam int SIZE_WIDTH     = 3;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } ar_state_e;

    // Width of an index able to address n ports (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_rd_rr_arb_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr_i, cyclically.
// Ports: req_i request vector, ptr_i search start; gnt_o one-hot grant,
// idx_o grant index, any_o high when any request is asserted.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any_o && req_i[(int'(ptr_i) + i) % N]) begin
                any_o                         = 1'b1;
                gnt_o[(int'(ptr_i) + i) % N]  = 1'b1;
                idx_o                         = IW'((int'(ptr_i) + i) % N);
            end
        end
    end

endmodule

// File: rtl/axi_rd_rr_arb.sv
// AXI read-channel round-robin arbiter: NUM_PORTS requesters share one
// downstream AR/R port. The port index is carried in the low TAG_BITS of
// the downstream ID and used to route R beats back.
// Ports: clk/rst_n; per-port s_ar* / s_r*; downstream m_ar* / m_r*;
// idle (nothing outstanding or pending); err_bad_rid (sticky bad R tag).
//
// state   | meaning
// ST_ARB  | combinational round-robin grant among eligible requesters
// ST_HOLD | downstream stalled; keep presenting the registered grant
module axi_rd_rr_arb
    import axi_rd_rr_arb_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int TAG_BITS  = DEF_TAG_BITS,
    parameter int ID_WIDTH  = DEF_ID_WIDTH,
    parameter int MAX_OUTST = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_PORTS-1:0]                  s_arvalid,
    output logic [NUM_PORTS-1:0]                  s_arready,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  s_araddr,
    input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0]    s_arid,
    input  logic [NUM_PORTS-1:0][LEN_WIDTH-1:0]   s_arlen,
    input  logic [NUM_PORTS-1:0][SIZE_WIDTH-1:0]  s_arsize,
    output logic [NUM_PORTS-1:0]                  s_rvalid,
    input  logic [NUM_PORTS-1:0]                  s_rready,
    output logic [DATA_WIDTH-1:0]                 s_rdata,
    output logic [ID_WIDTH-1:0]                   s_rid,
    output logic                                  s_rlast,
    output logic [1:0]                            s_rresp,
    output logic                                  m_arvalid,
    input  logic                                  m_arready,
    output logic [ADDR_WIDTH-1:0]                 m_araddr,
    output logic [ID_WIDTH-1:0]                   m_arid,
    output logic [LEN_WIDTH-1:0]                  m_arlen,
    output logic [SIZE_WIDTH-1:0]                 m_arsize,
    input  logic                                  m_rvalid,
    output logic                                  m_rready,
    input  logic [DATA_WIDTH-1:0]                 m_rdata,
    input  logic [ID_WIDTH-1:0]                   m_rid,
    input  logic                                  m_rlast,
    input  logic [1:0]                            m_rresp,
    output logic                                  idle,
    output logic                                  err_bad_rid
);

    localparam int IW = idx_width(NUM_PORTS);
    localparam int CW = $clog2(MAX_OUTST + 1);

    ar_state_e                   state_q, state_d;
    logic [IW-1:0]               hold_q, hold_d;
    logic [IW-1:0]               rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0][CW-1:0] cnt_q, cnt_d;
    logic                        err_q, err_d;

    logic [NUM_PORTS-1:0]        elig, pick_gnt;
    logic [IW-1:0]               pick_idx, gnt_idx;
    logic                        pick_any, ar_hs;
    logic [TAG_BITS-1:0]         r_tag;
    logic                        tag_ok, rlast_hs;
    logic                        unused_arid_lo;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            elig[p] = s_arvalid[p] && (cnt_q[p] < CW'(MAX_OUTST));
        end
    end

    rr_pick #(.N(NUM_PORTS), .IW(IW)) u_pick (
        .req_i (elig),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        gnt_idx   = pick_idx;
        m_arvalid = pick_any;
        s_arready = '0;
        unique case (state_q)
            ST_ARB: begin
                if (m_arready) begin
                    s_arready = pick_gnt;
                end else if (pick_any) begin
                    state_d = ST_HOLD;
                    hold_d  = pick_idx;
                end
            end
            ST_HOLD: begin
                // Other requesters are ignored until the held AR is taken.
                gnt_idx   = hold_q;
                m_arvalid = s_arvalid[hold_q];
                if (m_arready) begin
                    s_arready[hold_q] = m_arvalid;
                    state_d           = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    assign ar_hs    = m_arvalid && m_arready;
    assign rr_ptr_d = !ar_hs ? rr_ptr_q :
                      (gnt_idx == IW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;

    assign m_araddr = s_araddr[gnt_idx];
    assign m_arlen  = s_arlen[gnt_idx];
    assign m_arsize = s_arsize[gnt_idx];
    assign m_arid   = {s_arid[gnt_idx][ID_WIDTH-1:TAG_BITS], TAG_BITS'(gnt_idx)};

    // Requester-side low ID bits are overwritten by the port tag.
    assign unused_arid_lo = ^s_arid[gnt_idx][TAG_BITS-1:0];

    // R routing; beats with an out-of-range tag are sunk and flagged.
    assign r_tag  = m_rid[TAG_BITS-1:0];
    assign tag_ok = (32'(r_tag) < NUM_PORTS);

    always_comb begin
        s_rvalid = '0;
        m_rready = 1'b1;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (tag_ok && (r_tag == TAG_BITS'(p))) begin
                s_rvalid[p] = m_rvalid;
                m_rready    = s_rready[p];
            end
        end
    end

    assign s_rdata = m_rdata;
    assign s_rlast = m_rlast;
    assign s_rresp = m_rresp;
    assign s_rid   = {{TAG_BITS{1'b0}}, m_rid[ID_WIDTH-1:TAG_BITS]};

    assign rlast_hs = m_rvalid && m_rready && m_rlast && tag_ok;
    assign err_d    = err_q || (m_rvalid && !tag_ok);

    // Increment is only possible below MAX_OUTST (eligibility), decrement
    // is guarded against zero, so counters never wrap.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            logic inc, dec;
            inc      = ar_hs && (gnt_idx == IW'(p));
            dec      = rlast_hs && (r_tag == TAG_BITS'(p));
            cnt_d[p] = cnt_q[p];
            if (inc && !dec && (cnt_q[p] < CW'(MAX_OUTST))) begin
                cnt_d[p] = cnt_q[p] + 1'b1;
            end else if (dec && !inc && (cnt_q[p] != '0)) begin
                cnt_d[p] = cnt_q[p] - 1'b1;
            end
        end
    end

    assign idle        = (cnt_q == '0) && !m_arvalid;
    assign err_bad_rid = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ARB;
            hold_q   <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_rr_arb.sv
// Directed bench for axi_rd_rr_arb with NUM_PORTS=3, TAG_BITS=2,
// ID_WIDTH=16, MAX_OUTST=16. Inputs change 1ns after the rising edge and
// outputs are compared 1ns later, well clear of the next edge.
module tb_axi_rd_rr_arb;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        s_arvalid, s_arready;
    logic [2:0][63:0]  s_araddr;
    logic [2:0][15:0]  s_arid;
    logic [2:0][7:0]   s_arlen;
    logic [2:0][2:0]   s_arsize;
    logic [2:0]        s_rvalid, s_rready;
    logic [511:0]      s_rdata;
    logic [15:0]       s_rid;
    logic              s_rlast;
    logic [1:0]        s_rresp;
    logic              m_arvalid, m_arready;
    logic [63:0]       m_araddr;
    logic [15:0]       m_arid;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic              m_rvalid, m_rready;
    logic [511:0]      m_rdata;
    logic [15:0]       m_rid;
    logic              m_rlast;
    logic [1:0]        m_rresp;
    logic              idle, err_bad_rid;

    int n_cmp = 0;
    int n_bad = 0;

    axi_rd_rr_arb #(.NUM_PORTS(3), .TAG_BITS(2), .ID_WIDTH(16), .MAX_OUTST(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rid(s_rid), .s_rlast(s_rlast), .s_rresp(s_rresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rid(m_rid), .m_rlast(m_rlast), .m_rresp(m_rresp),
        .idle(idle), .err_bad_rid(err_bad_rid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        s_arvalid = '0;
        s_araddr  = {64'h3000, 64'h2000, 64'h1000};
        s_arid    = {16'h1234, 16'h0510, 16'h0A00};
        s_arlen   = {8'd7, 8'd3, 8'd1};
        s_arsize  = {3'd6, 3'd5, 3'd4};
        s_rready  = '0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = {8{64'hDEAD_BEEF_0000_0000}};
        m_rid     = '0;
        m_rlast   = 1'b0;
        m_rresp   = 2'b00;

        #2;
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_arvalid", 64'(m_arvalid), 64'd0);
        chk("rst_arready", 64'(s_arready), 64'd0);
        chk("rst_err", 64'(err_bad_rid), 64'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Three continuous requesters: 0,1,2,0,1,2
        s_arvalid = 3'b111;
        m_arready = 1'b1;
        #1;
        chk("rr_g0", 64'(s_arready), 64'b001);
        chk("rr_g0_id", 64'(m_arid), 64'h0A00);
        chk("rr_g0_addr", m_araddr, 64'h1000);
        chk("rr_busy_idle", 64'(idle), 64'd0);
        cyc(); #1; chk("rr_g1", 64'(s_arready), 64'b010);
        chk("rr_g1_id", 64'(m_arid), 64'h0511);
        cyc(); #1; chk("rr_g2", 64'(s_arready), 64'b100);
        chk("rr_g2_len", 64'(m_arlen), 64'd7);
        cyc(); #1; chk("rr_g3", 64'(s_arready), 64'b001);
        cyc(); #1; chk("rr_g4", 64'(s_arready), 64'b010);
        cyc(); #1; chk("rr_g5", 64'(s_arready), 64'b100);
        cyc();

        // Stall with port 1; port 0 joins while held
        s_arvalid = 3'b010;
        m_arready = 1'b0;
        #1;
        chk("hold_t0_tag", 64'(m_arid[1:0]), 64'd1);
        chk("hold_t0_rdy", 64'(s_arready), 64'b000);
        chk("hold_t0_vld", 64'(m_arvalid), 64'd1);
        cyc(); #1; chk("hold_t1_tag", 64'(m_arid[1:0]), 64'd1);
        cyc();
        s_arvalid = 3'b011;
        #1;
        chk("hold_t2_tag", 64'(m_arid[1:0]), 64'd1);
        chk("hold_t2_rdy", 64'(s_arready), 64'b000);
        cyc();
        m_arready = 1'b1;
        #1;
        chk("hold_hs", 64'(s_arready), 64'b010);
        cyc();
        s_arvalid = 3'b001;
        #1;
        chk("hold_next_p0", 64'(s_arready), 64'b001);
        chk("hold_next_tag", 64'(m_arid[1:0]), 64'd0);
        cyc();
        s_arvalid = 3'b000;
        // Outstanding now p0=3, p1=3, p2=2

        // ID tagging and R routing for port 2
        s_arvalid = 3'b100;
        #1;
        chk("tag_arid", 64'(m_arid), 64'h1236);
        chk("tag_addr", m_araddr, 64'h3000);
        cyc();
        s_arvalid = 3'b000;
        m_rvalid  = 1'b1;
        m_rid     = 16'h1236;
        m_rlast   = 1'b1;
        m_rresp   = 2'b10;
        s_rready  = 3'b000;
        #1;
        chk("r_svalid", 64'(s_rvalid), 64'b100);
        chk("r_sid", 64'(s_rid), 64'h048D);
        chk("r_mready_bp", 64'(m_rready), 64'd0);
        chk("r_data", s_rdata[63:0], 64'hDEAD_BEEF_0000_0000);
        chk("r_resp", 64'(s_rresp), 64'd2);
        s_rready = 3'b100;
        #1;
        chk("r_mready", 64'(m_rready), 64'd1);
        cyc();
        m_rid    = 16'h0000;
        m_rresp  = 2'b00;
        s_rready = 3'b001;
        #1;
        chk("r_p0_route", 64'(s_rvalid), 64'b001);
        cyc(); cyc(); cyc();
        // Outstanding now p0=0, p1=3, p2=2 (five bursts)

        // Out-of-range tag
        m_rid    = 16'h0003;
        s_rready = 3'b000;
        #1;
        chk("bad_mready", 64'(m_rready), 64'd1);
        chk("bad_svalid", 64'(s_rvalid), 64'b000);
        cyc();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        chk("bad_err_set", 64'(err_bad_rid), 64'd1);
        cyc(); #1;
        chk("bad_err_sticky", 64'(err_bad_rid), 64'd1);
        chk("outst_not_idle", 64'(idle), 64'd0);

        // Reset with five bursts outstanding
        rst_n = 1'b0;
        #1;
        chk("mid_rst_idle", 64'(idle), 64'd1);
        chk("mid_rst_err", 64'(err_bad_rid), 64'd0);
        cyc();
        rst_n = 1'b1;
        s_arvalid = 3'b111;
        #1;
        chk("restart_p0", 64'(s_arready), 64'b001);
        cyc();

        // Port 0 fills its 16 outstanding slots
        s_arvalid = 3'b001;
        for (int i = 0; i < 15; i++) cyc();
        #1;
        chk("full_blocked", 64'(m_arvalid), 64'd0);
        chk("full_rdy", 64'(s_arready), 64'b000);
        s_arvalid = 3'b101;
        #1;
        chk("full_p2_granted", 64'(s_arready), 64'b100);
        cyc();
        s_arvalid = 3'b001;
        m_rvalid  = 1'b1;
        m_rid     = 16'h0000;
        m_rlast   = 1'b1;
        s_rready  = 3'b001;
        #1;
        chk("full_r_mready", 64'(m_rready), 64'd1);
        chk("full_still_blk", 64'(m_arvalid), 64'd0);
        cyc();
        m_rvalid = 1'b0;
        #1;
        chk("freed_vld", 64'(m_arvalid), 64'd1);
        chk("freed_rdy", 64'(s_arready), 64'b001);
        // AR handshake and rlast for port 0 in the same cycle: count stays 15
        m_rvalid = 1'b1;
        cyc();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        chk("both_same_cyc", 64'(m_arvalid), 64'd1);
        cyc(); #1;
        chk("refull_blocked", 64'(m_arvalid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
